// File: rtl/ps2_key_decoder_if.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder_if
// Ready/valid event stream between the PS/2 key decoder and the game logic.
//   ev_valid : decoder -> consumer, event FIFO is non-empty
//   ev_ready : consumer -> decoder, head is popped when ev_valid & ev_ready
//   ev_data  : decoder -> consumer, head event {ext, brk, code[7:0]}
// The master modport is the decoder side; the slave modport is the consumer.
// ---------------------------------------------------------------------------
interface ps2_key_decoder_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [9:0] ev_data;

  modport master (
    output ev_valid,
    output ev_data,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_data,
    output ev_ready
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
// PS/2 keyboard receiver. Synchronises and de-glitches the PS/2 clock,
// deframes 11-bit frames (start, 8 data LSB first, odd parity, stop) with a
// timeout resync, decodes the E0 (extended) and F0 (break) prefixes, tracks a
// held/released bit per configured key and queues every make/break code in a
// ready/valid event FIFO.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   ps2_clk_i    raw PS/2 clock pin (asynchronous)
//   ps2_data_i   raw PS/2 data pin (asynchronous)
//   key_state_o  bit i = 1 while configured key i is held
//   frame_err_o  one-cycle pulse per dropped frame (parity, stop, timeout)
//   overflow_o   sticky, set when an event was dropped because the FIFO was full
//   ev_if        event stream (master side): ev_valid, ev_ready, ev_data
// ---------------------------------------------------------------------------
module ps2_key_decoder #(
  parameter int                   FILT_LEN    = 4,
  parameter int                   TIMEOUT_CYC = 5000,
  parameter int                   FIFO_DEPTH  = 8,
  parameter int                   NKEYS       = 4,
  parameter logic [NKEYS*8-1:0]   KEY_CODES   = 32'h75_72_6B_74,
  parameter logic [NKEYS-1:0]     KEY_EXT     = 4'b1111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ps2_clk_i,
  input  logic              ps2_data_i,
  output logic [NKEYS-1:0]  key_state_o,
  output logic              frame_err_o,
  output logic              overflow_o,
  ps2_key_decoder_if.master ev_if
);

  localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT_LEN - 1);
  localparam logic [TCW-1:0] TO_MAX    = TCW'(TIMEOUT_CYC);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // Odd parity over data byte plus received parity bit.
  function automatic logic frame_parity_ok(input logic [7:0] data, input logic par);
    frame_parity_ok = ^{data, par};
  endfunction

  // ------------------------------------------------------------------
  // Input synchronisers and clock filter
  // ------------------------------------------------------------------
  logic           clk_meta_q, clk_sync_q;
  logic           data_meta_q, data_sync_q;
  logic           filt_clk_q, filt_clk_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  logic           fall_s;

  // Two-flop synchronisers for both pins; idle PS/2 lines are high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_i;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data_i;
      data_sync_q <= data_meta_q;
    end
  end

  // Filtered clock follows the synced clock only after FILT_LEN
  // consecutive samples that differ from the current filtered level.
  always_comb begin
    filt_clk_d = filt_clk_q;
    filt_cnt_d = {FCW{1'b0}};
    if (clk_sync_q == filt_clk_q) begin
      filt_cnt_d = {FCW{1'b0}};
    end else if (filt_cnt_q == FILT_LAST) begin
      filt_clk_d = clk_sync_q;
      filt_cnt_d = {FCW{1'b0}};
    end else begin
      filt_cnt_d = filt_cnt_q + {{(FCW-1){1'b0}}, 1'b1};
    end
  end

  assign fall_s = filt_clk_q & ~filt_clk_d;

  // Filter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_clk_q <= 1'b1;
      filt_cnt_q <= {FCW{1'b0}};
    end else begin
      filt_clk_q <= filt_clk_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // ------------------------------------------------------------------
  // Frame FSM with timeout
  // ------------------------------------------------------------------
  logic [1:0]     state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           parity_q, parity_d;
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic           byte_valid_q, byte_valid_d;
  logic           frame_err_q, frame_err_d;
  logic           timeout_s;

  assign timeout_s = (state_q != ST_IDLE) && (to_cnt_q == TO_MAX);

  // Timeout counter: cleared on every fall and while idle, saturates at TO_MAX.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (fall_s || (state_q == ST_IDLE)) begin
      to_cnt_d = {TCW{1'b0}};
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + {{(TCW-1){1'b0}}, 1'b1};
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  // Frame deframing: start, 8 data bits LSB first, parity, stop.
  // shift_q keeps the last byte after STOP, so it doubles as the decoded byte.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (timeout_s) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
    end else if (fall_s) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_sync_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            state_d   = ST_IDLE;
          end
        end
        ST_DATA: begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_PARITY: begin
          parity_d = data_sync_q;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (frame_parity_ok(shift_q, parity_q) && data_sync_q) begin
            byte_valid_d = 1'b1;
          end else begin
            frame_err_d  = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FSM and frame registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      parity_q     <= 1'b0;
      to_cnt_q     <= {TCW{1'b0}};
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      to_cnt_q     <= to_cnt_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // ------------------------------------------------------------------
  // Prefix decode and key state
  // ------------------------------------------------------------------
  logic             ext_q, ext_d;
  logic             brk_q, brk_d;
  logic [NKEYS-1:0] key_q, key_d;
  logic             push_s;
  logic [9:0]       push_data_s;

  assign push_data_s = {ext_q, brk_q, shift_q};

  // Decode a good byte one cycle after its STOP fall. A dropped frame clears
  // any pending prefixes so a stale E0/F0 cannot attach to a later code.
  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    key_d  = key_q;
    push_s = 1'b0;
    if (frame_err_d) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_valid_q) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        push_s = 1'b1;
        for (int i = 0; i < NKEYS; i++) begin
          if ((KEY_CODES[8*i +: 8] == shift_q) && (KEY_EXT[i] == ext_q)) begin
            key_d[i] = ~brk_q;
          end else begin
            key_d[i] = key_q[i];
          end
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end else begin
      push_s = 1'b0;
    end
  end

  // Prefix and key-state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      key_q <= {NKEYS{1'b0}};
    end else begin
      ext_q <= ext_d;
      brk_q <= brk_d;
      key_q <= key_d;
    end
  end

  // ------------------------------------------------------------------
  // Event FIFO (extra pointer bit distinguishes full from empty)
  // ------------------------------------------------------------------
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [9:0]  mem_q [FIFO_DEPTH];
  logic        empty_s, full_s, pop_s, wr_en_s, ovf_set_s;
  logic        ovf_q;

  assign empty_s   = (wr_ptr_q == rd_ptr_q);
  assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_s     = ~empty_s & ev_if.ev_ready;
  // When full, a same-cycle pop frees the slot being written.
  assign wr_en_s   = push_s & (~full_s | pop_s);
  assign ovf_set_s = push_s & full_s & ~pop_s;

  // FIFO storage, pointers and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
      ovf_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 10'd0;
      end
    end else begin
      if (wr_en_s) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data_s;
        wr_ptr_q                <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (ovf_set_s) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign ev_if.ev_valid = ~empty_s;
  assign ev_if.ev_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign key_state_o    = key_q;
  assign frame_err_o    = frame_err_q;
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
`timescale 1ns/1ps
// Bench for ps2_key_decoder with default parameters. The system clock is
// ~1.2 MHz and each PS/2 bit spans 100 clocks, giving a ~12 kHz bit-rate.
// Stimulus pushes expected events into exp_q; a monitor process pops and
// compares whenever the DUT hands over an event.
module tb_ps2_key_decoder;
  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] key_state;
  logic       frame_err;
  logic       overflow;

  ps2_key_decoder_if ev_if ();

  ps2_key_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_data),
    .key_state_o (key_state),
    .frame_err_o (frame_err),
    .overflow_o  (overflow),
    .ev_if       (ev_if.master)
  );

  always #417 clk = ~clk;

  int         n_chk = 0;
  int         n_pass = 0;
  int         ferr_cnt = 0;
  logic [9:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: counts frame_err pulses, checks head stability while stalled and
  // compares every popped event against the scoreboard.
  initial begin : monitor
    logic       hold;
    logic [9:0] hold_data;
    logic [9:0] e;
    hold = 1'b0;
    hold_data = 10'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (frame_err) ferr_cnt++;
        if (hold && ev_if.ev_valid && !ev_if.ev_ready)
          chk("head_stable", {22'd0, ev_if.ev_data}, {22'd0, hold_data});
        if (ev_if.ev_valid && ev_if.ev_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_event: got 0x%0h, expected none (t=%0t)", ev_if.ev_data, $time);
          end else begin
            e = exp_q.pop_front();
            chk("event", {22'd0, ev_if.ev_data}, {22'd0, e});
          end
        end
        hold = ev_if.ev_valid && !ev_if.ev_ready;
        hold_data = ev_if.ev_data;
      end
    end
  end

  // Sends one frame (or its first nbits bits). glitch_bit puts a 2-cycle low
  // pulse in that bit's high phase. pop_mode pulses ev_ready during the cycle
  // the FIFO write happens; lat_mode checks outputs at cycles N+1 and N+2.
  task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0,
                            input bit bad_stop = 1'b0, input int nbits = 11,
                            input int glitch_bit = -1, input bit pop_mode = 1'b0,
                            input bit lat_mode = 1'b0, input logic [3:0] prev_keys = 4'd0,
                            input logic [3:0] lat_keys = 4'd0);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      if (i == glitch_bit) begin
        wait_cyc(HALF / 2);
        ps2_clk = 1'b0;
        wait_cyc(2);
        ps2_clk = 1'b1;
        wait_cyc(HALF - HALF / 2 - 2);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b0;
      for (int k = 1; k <= HALF; k++) begin
        wait_cyc(1);
        if (i == 10 && pop_mode && k == 6) ev_if.ev_ready = 1'b1;
        if (i == 10 && pop_mode && k == 7) ev_if.ev_ready = 1'b0;
        if (i == 10 && lat_mode && k == 6) begin
          chk("lat_valid_n1", {31'd0, ev_if.ev_valid}, 32'd0);
          chk("lat_keys_n1", {28'd0, key_state}, {28'd0, prev_keys});
        end
        if (i == 10 && lat_mode && k == 7) begin
          chk("lat_valid_n2", {31'd0, ev_if.ev_valid}, 32'd1);
          chk("lat_keys_n2", {28'd0, key_state}, {28'd0, lat_keys});
        end
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic chk_outputs_reset(input string tag);
    chk({tag, "_key_state"}, {28'd0, key_state}, 32'd0);
    chk({tag, "_ev_valid"}, {31'd0, ev_if.ev_valid}, 32'd0);
    chk({tag, "_ev_data"}, {22'd0, ev_if.ev_data}, 32'd0);
    chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
  endtask

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got no finish, expected finish within 90000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] codes [8];
    codes[0] = 8'h15; codes[1] = 8'h1D; codes[2] = 8'h24; codes[3] = 8'h2D;
    codes[4] = 8'h2C; codes[5] = 8'h35; codes[6] = 8'h3C; codes[7] = 8'h43;
    ev_if.ev_ready = 1'b1;
    rst_n = 1'b0;
    wait_cyc(5);
    chk_outputs_reset("reset");
    rst_n = 1'b1;
    wait_cyc(10);

    // 1: extended make then break of slot 3 (0x75), with latency check.
    send_frame(8'hE0);
    exp_q.push_back(10'h275);
    send_frame(8'h75, .lat_mode(1'b1), .prev_keys(4'b0000), .lat_keys(4'b1000));
    chk("t1_make", {28'd0, key_state}, 32'h8);
    send_frame(8'hE0);
    send_frame(8'hF0);
    exp_q.push_back(10'h375);
    send_frame(8'h75);
    chk("t1_break", {28'd0, key_state}, 32'h0);

    // 2: non-extended 0x75 does not match, still produces an event.
    exp_q.push_back(10'h075);
    send_frame(8'h75);
    chk("t2_keys", {28'd0, key_state}, 32'h0);
    chk("t2_no_ferr", ferr_cnt, 32'd0);

    // 3: bad parity dropped, then a good E0 6B; then E0 + bad stop clears prefix.
    send_frame(8'h6B, .bad_par(1'b1));
    chk("t3_ferr_par", ferr_cnt, 32'd1);
    send_frame(8'hE0);
    exp_q.push_back(10'h26B);
    send_frame(8'h6B);
    chk("t3_keys", {28'd0, key_state}, 32'h2);
    send_frame(8'hE0);
    send_frame(8'h74, .bad_stop(1'b1));
    chk("t3_ferr_stop", ferr_cnt, 32'd2);
    exp_q.push_back(10'h074);
    send_frame(8'h74);
    chk("t3_prefix_cleared", {28'd0, key_state}, 32'h2);

    // 4: partial frame, then silence past the timeout.
    send_frame(8'h00, .nbits(5));
    wait_cyc(4400);
    chk("t4_no_early_timeout", ferr_cnt, 32'd2);
    wait_cyc(900);
    chk("t4_timeout", ferr_cnt, 32'd3);
    send_frame(8'hE0);
    exp_q.push_back(10'h272);
    send_frame(8'h72);
    chk("t4_keys", {28'd0, key_state}, 32'h6);

    // 5: fill the FIFO, push+pop while full, overflow, then drain.
    wait_cyc(5);
    chk("t5_start_empty", exp_q.size(), 32'd0);
    ev_if.ev_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({2'b00, codes[i]});
      send_frame(codes[i]);
    end
    chk("t5_full_no_ovf", {31'd0, overflow}, 32'd0);
    chk("t5_head", {22'd0, ev_if.ev_data}, 32'h015);
    exp_q.push_back(10'h044);
    send_frame(8'h44, .pop_mode(1'b1));
    chk("t5_pushpop_no_ovf", {31'd0, overflow}, 32'd0);
    chk("t5_head_after_pop", {22'd0, ev_if.ev_data}, 32'h01D);
    send_frame(8'hE0);
    send_frame(8'h74);
    chk("t5_ovf", {31'd0, overflow}, 32'd1);
    chk("t5_keys_on_drop", {28'd0, key_state}, 32'h7);
    chk("t5_head_stable", {22'd0, ev_if.ev_data}, 32'h01D);
    ev_if.ev_ready = 1'b1;
    wait_cyc(20);
    chk("t5_drained_valid", {31'd0, ev_if.ev_valid}, 32'd0);
    chk("t5_drained_all", exp_q.size(), 32'd0);
    chk("t5_ovf_sticky", {31'd0, overflow}, 32'd1);

    // 6: glitch mid-frame is ignored; reset mid-frame clears everything.
    send_frame(8'hE0);
    send_frame(8'hF0, .glitch_bit(4));
    exp_q.push_back(10'h36B);
    send_frame(8'h6B);
    chk("t6_glitch_keys", {28'd0, key_state}, 32'h5);
    chk("t6_glitch_no_ferr", ferr_cnt, 32'd3);
    send_frame(8'h74, .nbits(4));
    rst_n = 1'b0;
    wait_cyc(3);
    chk_outputs_reset("t6_reset");
    rst_n = 1'b1;
    wait_cyc(10);
    send_frame(8'hE0);
    exp_q.push_back(10'h274);
    send_frame(8'h74);
    chk("t6_after_reset_keys", {28'd0, key_state}, 32'h1);
    chk("t6_after_reset_ferr", ferr_cnt, 32'd3);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) wait_cyc(1);
    chk("final_all_events_seen", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
